// File: rtl/test_mode_sequencer.sv
// rtl/test_mode_sequencer.sv - test pattern mode sequencer with button, switch and auto-cycle selection
// Mode changes are applied only at frame boundaries; the pixel path is one registered stage.
module test_mode_sequencer #(
  parameter int NUM_MODES    = 7,
  parameter int COLOR_W      = 4,
  parameter int SW_W         = 10,
  parameter int DWELL_FRAMES = 120,
  localparam int MODE_W      = $clog2(NUM_MODES)
) (
  input  logic                           clock25MHz,
  input  logic                           reset,
  input  logic [SW_W-1:0]                switches,
  input  logic                           nextButton,
  input  logic                           prevButton,
  input  logic                           autoEnable,
  input  logic                           canDisplayImage,
  input  logic                           hsync_in,
  input  logic                           vsync_in,
  input  logic [NUM_MODES*3*COLOR_W-1:0] pattern_rgb,
  output logic [COLOR_W-1:0]             red,
  output logic [COLOR_W-1:0]             green,
  output logic [COLOR_W-1:0]             blue,
  output logic                           hsync,
  output logic                           vsync,
  output logic [MODE_W-1:0]              currentMode,
  output logic                           overrideActive
);

  localparam int PIX_W = 3 * COLOR_W;
  localparam int DW_W  = $clog2(DWELL_FRAMES + 1);
  localparam logic [DW_W-1:0]   DWELL_LAST = DW_W'(DWELL_FRAMES - 1);
  localparam logic [MODE_W-1:0] MODE_LAST  = MODE_W'(NUM_MODES - 1);

  logic              next_q, prev_q, vsync_q;
  logic [MODE_W-1:0] pending_mode, pending_d, pend_stepped, sel_mode, sw_idx;
  logic [DW_W-1:0]   dwell_cnt, dwell_d;
  logic              next_edge, prev_edge, step_next, step_prev, collision;
  logic              frame_bnd, sw_hit, sw_onehot, override_valid, advance;
  logic [PIX_W-1:0]  slice;

  function automatic logic [MODE_W-1:0] mode_inc(input logic [MODE_W-1:0] m);
    return (m == MODE_LAST) ? '0 : m + 1'b1;
  endfunction

  function automatic logic [MODE_W-1:0] mode_dec(input logic [MODE_W-1:0] m);
    return (m == '0) ? MODE_LAST : m - 1'b1;
  endfunction

  assign next_edge = nextButton & ~next_q;
  assign prev_edge = prevButton & ~prev_q;
  assign collision = next_edge & prev_edge;
  assign step_next = next_edge & ~prev_edge;
  assign step_prev = prev_edge & ~next_edge;
  assign frame_bnd = ~vsync_in & vsync_q;

  // Only bits below NUM_MODES can name a mode; a lone higher bit is no override.
  always_comb begin
    sw_idx = '0;
    sw_hit = 1'b0;
    for (int i = 0; i < NUM_MODES; i++) begin
      if (switches[i]) begin
        sw_idx = MODE_W'(i);
        sw_hit = 1'b1;
      end
    end
  end

  assign sw_onehot      = (switches != '0) && ((switches & (switches - 1'b1)) == '0);
  assign override_valid = sw_onehot & sw_hit;
  assign overrideActive = override_valid;

  always_comb begin
    pend_stepped = pending_mode;
    if (step_next)      pend_stepped = mode_inc(pending_mode);
    else if (step_prev) pend_stepped = mode_dec(pending_mode);
  end

  // A simultaneous next+prev freezes the dwell count along with pendingMode.
  always_comb begin
    dwell_d = dwell_cnt;
    advance = 1'b0;
    if (!autoEnable || override_valid || step_next || step_prev) begin
      dwell_d = '0;
    end else if (!collision && frame_bnd) begin
      if (dwell_cnt == DWELL_LAST) begin
        dwell_d = '0;
        advance = 1'b1;
      end else begin
        dwell_d = dwell_cnt + 1'b1;
      end
    end
  end

  assign pending_d = advance ? mode_inc(pend_stepped) : pend_stepped;
  assign sel_mode  = override_valid ? sw_idx : pending_d;
  assign slice     = pattern_rgb[int'(currentMode) * PIX_W +: PIX_W];

  always_ff @(posedge clock25MHz or posedge reset) begin
    if (reset) begin
      next_q       <= 1'b0;
      prev_q       <= 1'b0;
      vsync_q      <= 1'b0;
      pending_mode <= '0;
      currentMode  <= '0;
      dwell_cnt    <= '0;
      red          <= '0;
      green        <= '0;
      blue         <= '0;
      hsync        <= 1'b1;
      vsync        <= 1'b1;
    end else begin
      next_q       <= nextButton;
      prev_q       <= prevButton;
      vsync_q      <= vsync_in;
      pending_mode <= pending_d;
      dwell_cnt    <= dwell_d;
      if (frame_bnd) currentMode <= sel_mode;
      {red, green, blue} <= canDisplayImage ? slice : '0;
      hsync        <= hsync_in;
      vsync        <= vsync_in;
    end
  end

endmodule

// File: tb/tb_test_mode_sequencer.sv
// tb/tb_test_mode_sequencer.sv - self-checking bench for test_mode_sequencer
module tb_test_mode_sequencer;

  localparam int NM = 7;
  localparam int CW = 4;
  localparam int SW = 10;

  logic            clk = 1'b0;
  logic            reset;
  logic [SW-1:0]   switches;
  logic            next_b, prev_b, auto_en, cdi, hs_in, vs_in;
  logic [NM*3*CW-1:0] pattern_rgb;
  logic [CW-1:0]   red, green, blue;
  logic            hsync, vsync, ovr;
  logic [2:0]      mode;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [SW-1:0] sw;
    logic          exp_ovr;
    int            exp_mode;
  } ovr_vec_t;

  ovr_vec_t vecs[8];
  logic [11:0] slices[NM];

  always #20 clk = ~clk;

  test_mode_sequencer #(.NUM_MODES(NM), .COLOR_W(CW), .SW_W(SW), .DWELL_FRAMES(3)) dut (
    .clock25MHz(clk), .reset(reset), .switches(switches),
    .nextButton(next_b), .prevButton(prev_b), .autoEnable(auto_en),
    .canDisplayImage(cdi), .hsync_in(hs_in), .vsync_in(vs_in),
    .pattern_rgb(pattern_rgb), .red(red), .green(green), .blue(blue),
    .hsync(hsync), .vsync(vsync), .currentMode(mode), .overrideActive(ovr)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    vs_in = 1'b0;
    tick();
    vs_in = 1'b1;
    tick();
  endtask

  task automatic press(input logic n, input logic p);
    next_b = n;
    prev_b = p;
    tick();
    next_b = 1'b0;
    prev_b = 1'b0;
    tick();
  endtask

  initial begin
    slices = '{12'h123, 12'h456, 12'hF0A, 12'h789, 12'hABC, 12'hDEF, 12'h5A5};
    for (int k = 0; k < NM; k++) pattern_rgb[k*12 +: 12] = slices[k];
    vecs[0] = '{10'b0000010000, 1'b1, 4};
    vecs[1] = '{10'b0000110000, 1'b0, 1};
    vecs[2] = '{10'b0000000000, 1'b0, 1};
    vecs[3] = '{10'b0000000001, 1'b1, 0};
    vecs[4] = '{10'b0001000000, 1'b1, 6};
    vecs[5] = '{10'b0010000000, 1'b0, 1};
    vecs[6] = '{10'b1000000000, 1'b0, 1};
    vecs[7] = '{10'b0000000100, 1'b1, 2};

    reset = 1'b1; switches = '0; next_b = 0; prev_b = 0; auto_en = 0;
    cdi = 1'b1; hs_in = 1'b0; vs_in = 1'b0;
    tick(); tick();
    check("reset_mode", mode, 0);
    check("reset_rgb", {red, green, blue}, 0);
    check("reset_hsync", hsync, 1);
    check("reset_vsync", vsync, 1);
    hs_in = 1'b1; vs_in = 1'b1;
    reset = 1'b0;
    tick();

    // wrap from 6 to 0 via next
    press(0, 1);
    frame();
    check("wrap_prev_to_6", mode, 6);
    press(1, 0);
    check("hold_until_boundary", mode, 6);
    frame();
    check("wrap_next_to_0", mode, 0);

    press(1, 0);
    frame();
    check("pending_1", mode, 1);
    for (int i = 0; i < 8; i++) begin
      switches = vecs[i].sw;
      #1;
      check($sformatf("ovr_flag_%0d", i), ovr, vecs[i].exp_ovr);
      frame();
      check($sformatf("ovr_mode_%0d", i), mode, vecs[i].exp_mode);
    end
    switches = '0;

    // simultaneous presses ignored
    press(1, 0); press(1, 0);
    press(1, 1);
    frame();
    check("collision_pending_3", mode, 3);

    // pixel path and sync delay at mode 2
    press(0, 1);
    frame();
    check("mode_2", mode, 2);
    cdi = 1'b0;
    tick();
    check("rgb_blank", {red, green, blue}, 0);
    cdi = 1'b1;
    #1;
    check("rgb_before_edge", {red, green, blue}, 0);
    tick();
    check("rgb_active", {red, green, blue}, 12'hF0A);
    cdi = 1'b0;
    tick();
    check("rgb_off", {red, green, blue}, 0);
    hs_in = 1'b0;
    #1;
    check("hsync_pre", hsync, 1);
    tick();
    check("hsync_lag", hsync, 0);
    hs_in = 1'b1;
    tick();
    check("hsync_back", hsync, 1);
    vs_in = 1'b0;
    #1;
    check("vsync_pre", vsync, 1);
    tick();
    check("vsync_lag", vsync, 0);
    vs_in = 1'b1;
    tick();
    check("vsync_back", vsync, 1);
    cdi = 1'b1;

    // auto-cycle with 3-frame dwell
    press(0, 1); press(0, 1);
    frame();
    check("auto_start_0", mode, 0);
    auto_en = 1'b1;
    begin
      int exp_seq[6] = '{0, 0, 1, 1, 1, 2};
      for (int i = 0; i < 6; i++) begin
        frame();
        check($sformatf("auto_seq_%0d", i), mode, exp_seq[i]);
      end
    end
    frame();
    check("auto_pre_press", mode, 2);
    press(1, 0);
    frame(); check("restart_a", mode, 3);
    frame(); check("restart_b", mode, 3);
    frame(); check("restart_c", mode, 4);
    frame(); check("coll_a", mode, 4);
    press(1, 1);
    frame(); check("coll_b", mode, 4);
    frame(); check("coll_c", mode, 5);
    auto_en = 1'b0;

    // press coinciding with a frame boundary
    next_b = 1'b1; vs_in = 1'b0;
    tick();
    check("press_at_boundary", mode, 6);
    next_b = 1'b0; vs_in = 1'b1;
    tick();

    // presses during override take effect after removal
    switches = 10'b0000000001;
    frame(); check("ovr_hold_a", mode, 0);
    press(0, 1);
    frame(); check("ovr_hold_b", mode, 0);
    switches = '0;
    frame(); check("ovr_released", mode, 5);

    // asynchronous reset mid-frame
    tick();
    check("rgb_mode5", {red, green, blue}, 12'hDEF);
    hs_in = 1'b0;
    tick();
    #5 reset = 1'b1;
    #1;
    check("async_mode", mode, 0);
    check("async_rgb", {red, green, blue}, 0);
    check("async_hsync", hsync, 1);
    check("async_vsync", vsync, 1);
    #5 reset = 1'b0;
    hs_in = 1'b1;
    tick();
    check("post_reset_mode", mode, 0);
    press(1, 0);
    check("post_reset_hold", mode, 0);
    frame();
    check("post_reset_first_boundary", mode, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/test_mode_sequencer.md
TEST_MODE_SEQUENCER -- requirements
Module: test_mode_sequencer

Interface
REQ-001 Parameter NUM_MODES, default 7: number of pattern sources; legal range 2..SW_W.
REQ-002 Parameter COLOR_W, default 4: bits per colour channel.
REQ-003 Parameter SW_W, default 10: switch bus width.
REQ-004 Parameter DWELL_FRAMES, default 120: frames per mode in auto-cycle; legal range >= 1.
REQ-005 Derived MODE_W = clog2(NUM_MODES): width of the mode index.
REQ-006 clock25MHz  in  1  pixel clock; every register in the block uses its rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 switches  in  SW_W  one-hot mode override.
REQ-009 nextButton  in  1  debounced, level, active-high.
REQ-010 prevButton  in  1  debounced, level, active-high.
REQ-011 autoEnable  in  1  level; 1 enables auto-cycle.
REQ-012 canDisplayImage  in  1  active-video qualifier from the timing generator.
REQ-013 hsync_in, vsync_in  in  1 each  active-low syncs from the timing generator.
REQ-014 pattern_rgb  in  NUM_MODES*3*COLOR_W  slice k is {red,green,blue} of mode k, with red in the MSBs.
REQ-015 red, green, blue  out  COLOR_W each  registered pixel colour.
REQ-016 hsync, vsync  out  1 each  syncs, each delayed one cycle.
REQ-017 currentMode  out  MODE_W  active mode index, 0..NUM_MODES-1.
REQ-018 overrideActive  out  1  high while a valid switch override is selected.

Function
REQ-019 Button edge: a press is detected when the button is high this cycle and was low last cycle, using one registered previous sample per button.
REQ-020 Next press: pendingMode SHALL increment by 1, wrapping from NUM_MODES-1 to 0.
REQ-021 Prev press: pendingMode SHALL decrement by 1, wrapping from 0 to NUM_MODES-1.
REQ-022 Next and prev presses in the same cycle: both SHALL be ignored; pendingMode and the dwell counter are unchanged.
REQ-023 A held button SHALL produce exactly one step per press.
REQ-024 Frame boundary: a cycle in which vsync_in is 0 and its registered previous value is 1.
REQ-025 Override is valid when switches has exactly one bit set and that bit index is < NUM_MODES; any other pattern, including zero or multiple bits, is no override.
REQ-026 selMode = switch bit index when override is valid, else pendingMode.
REQ-027 currentMode SHALL load selMode only at a frame boundary, so mode changes never occur mid-frame.
REQ-028 overrideActive SHALL be combinational from switches.
REQ-029 Auto-cycle: when autoEnable=1 and no override is valid, the dwell counter increments at each frame boundary.
REQ-030 When the dwell counter would reach DWELL_FRAMES, it clears and pendingMode advances by one as in REQ-020; the advanced value is loaded into currentMode at that same boundary.
REQ-031 The dwell counter SHALL clear on any accepted button press, on an override becoming valid, and whenever autoEnable=0.
REQ-032 Button presses SHALL update pendingMode even while an override is active; the resulting mode takes effect once the override is removed.
REQ-033 Pixel path, one cycle latency: {red,green,blue} <= canDisplayImage ? slice(currentMode) : 0.
REQ-034 hsync <= hsync_in and vsync <= vsync_in, each registered, so syncs stay aligned with colour.
REQ-035 A button press coinciding with a frame boundary SHALL be included in the selMode loaded at that boundary.

Reset
REQ-036 While reset is high: pendingMode=0, currentMode=0, dwell counter=0, button/vsync history=0, red=green=blue=0, hsync=vsync=1.
REQ-037 Reset asserted mid-frame SHALL take effect immediately, without waiting for a clock edge.
REQ-038 After reset release, the first frame boundary loads selMode.

Verification
REQ-039 currentMode=6 (NUM_MODES=7), single next pulse, then a frame boundary -> pendingMode=0; currentMode stays 6 until the boundary, then becomes 0.
REQ-040 nextButton and prevButton rise in the same cycle with pendingMode=3 -> pendingMode remains 3 and the dwell counter is unchanged.
REQ-041 switches=10'b0000010000, pendingMode=1 -> overrideActive=1 and currentMode=4 after the next boundary; switches=10'b0000110000 -> overrideActive=0 and currentMode=1 after the next boundary.
REQ-042 DWELL_FRAMES=3, autoEnable=1, start at mode 0 -> currentMode reads 0,0,1,1,1,2 after six boundaries; a press between boundaries restarts the 3-frame count.
REQ-043 canDisplayImage toggles with slice 2=12'hF0A and currentMode=2 -> rgb={F,0,A} exactly one cycle after canDisplayImage=1, and 0 one cycle after it returns to 0; hsync/vsync lag their inputs by one cycle.
REQ-044 Assert reset mid-frame with currentMode=5 -> all outputs take their reset values immediately; currentMode=0 after release and stays 0 until the first boundary.
